timer_host_ctrl: RTL and testbench



---
 rtl/timer_host_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_timer_host_ctrl.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_host_ctrl.sv
// timer_host_ctrl
//   Avalon-MM master that programs and services the DE10-Lite interval timer
//   (16-bit register map) without a CPU. A start request writes period_l,
//   period_h and control; timeouts (av_irq) are acknowledged by a status
//   write, each producing a one-cycle tick and incrementing tick_count.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start, period     start request; period sampled with start
//   stop              stop request (held pending until RUN is reached)
//   busy, running     state != IDLE / timer armed
//   tick, tick_count  one pulse per serviced timeout / wrapping count
//   cfg_err           one-cycle pulse when a start is rejected
//   av_*              timer register bus (single-cycle, no waitrequest)
//
// Optional feature (define TIMER_HOST_SNAP_EN):
//   snap_req, snap_value, snap_valid -- counter snapshot read-back.

module timer_host_ctrl #(
    parameter int unsigned CONTINUOUS = 1,
    parameter int unsigned TICK_W     = 16,
    parameter int unsigned MIN_PERIOD = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       period,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              cfg_err,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              av_irq
`ifdef TIMER_HOST_SNAP_EN
    ,
    input  logic              snap_req,
    output logic [31:0]       snap_value,
    output logic              snap_valid
`endif
);

    localparam logic [15:0] CTRL_START = (CONTINUOUS != 0) ? 16'h0007 : 16'h0005;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        WR_STATUS,
        WR_STOP,
        CLR_STATUS
`ifdef TIMER_HOST_SNAP_EN
        ,
        SNAP_WR,
        SNAP_RD_L,
        SNAP_RD_H,
        SNAP_DONE
`endif
    } state_t;

    state_t              state_q;
    logic [31:0]         period_q;
    logic                stop_pend_q;
    logic [TICK_W-1:0]   tick_count_q;
    logic                tick_q;
    logic                cfg_err_q;
    logic [2:0]          addr_q;
    logic                cs_q;
    logic                wn_q;
    logic [15:0]         wd_q;
`ifdef TIMER_HOST_SNAP_EN
    logic                snap_pend_q;
    logic [31:0]         snap_value_q;
    logic                snap_valid_q;
`endif

    // Bus outputs are registered: the access shown while in a state was
    // set up on the transition into that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= '0;
            stop_pend_q  <= 1'b0;
            tick_count_q <= '0;
            tick_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= '0;
`ifdef TIMER_HOST_SNAP_EN
            snap_pend_q  <= 1'b0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
`endif
        end else begin
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            addr_q    <= '0;
            wd_q      <= '0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef TIMER_HOST_SNAP_EN
            snap_valid_q <= 1'b0;
            if (state_q != IDLE && snap_req) snap_pend_q <= 1'b1;
`endif
            if (state_q != IDLE && stop) stop_pend_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    stop_pend_q <= 1'b0;
`ifdef TIMER_HOST_SNAP_EN
                    snap_pend_q <= 1'b0;
`endif
                    if (start) begin
                        if (period >= 32'(MIN_PERIOD)) begin
                            period_q     <= period;
                            tick_count_q <= '0;
                            stop_pend_q  <= stop;
                            state_q      <= WR_PL;
                            cs_q         <= 1'b1;
                            wn_q         <= 1'b0;
                            addr_q       <= 3'd2;
                            wd_q         <= period[15:0];
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                WR_PL: begin
                    state_q <= WR_PH;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    addr_q  <= 3'd3;
                    wd_q    <= period_q[31:16];
                end
                WR_PH: begin
                    state_q <= WR_CTRL;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    addr_q  <= 3'd1;
                    wd_q    <= CTRL_START;
                end
                WR_CTRL: state_q <= RUN;
                RUN: begin
                    if (stop_pend_q || stop) begin
                        state_q <= WR_STOP;
                        cs_q    <= 1'b1;
                        wn_q    <= 1'b0;
                        addr_q  <= 3'd1;
                        wd_q    <= CTRL_STOP;
                    end else if (av_irq) begin
                        state_q      <= WR_STATUS;
                        cs_q         <= 1'b1;
                        wn_q         <= 1'b0;
                        tick_q       <= 1'b1;
                        tick_count_q <= tick_count_q + TICK_W'(1);
                    end
`ifdef TIMER_HOST_SNAP_EN
                    else if (snap_pend_q || snap_req) begin
                        state_q     <= SNAP_WR;
                        snap_pend_q <= 1'b0;
                        cs_q        <= 1'b1;
                        wn_q        <= 1'b0;
                        addr_q      <= 3'd4;
                    end
`endif
                end
                WR_STATUS: state_q <= (CONTINUOUS != 0) ? RUN : IDLE;
                WR_STOP: begin
                    // Clear any timeout that raced with the stop; no tick for it.
                    state_q <= CLR_STATUS;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                end
                CLR_STATUS: state_q <= IDLE;
`ifdef TIMER_HOST_SNAP_EN
                SNAP_WR: begin
                    state_q <= SNAP_RD_L;
                    cs_q    <= 1'b1;
                    addr_q  <= 3'd4;
                end
                SNAP_RD_L: begin
                    state_q <= SNAP_RD_H;
                    cs_q    <= 1'b1;
                    addr_q  <= 3'd5;
                end
                // readdata lags the read cycle by one clock.
                SNAP_RD_H: begin
                    state_q             <= SNAP_DONE;
                    snap_value_q[15:0]  <= av_readdata;
                end
                SNAP_DONE: begin
                    state_q             <= RUN;
                    snap_value_q[31:16] <= av_readdata;
                    snap_valid_q        <= 1'b1;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign running       = (state_q != IDLE) && (state_q != WR_PL) &&
                           (state_q != WR_PH) && (state_q != WR_CTRL);
    assign tick          = tick_q;
    assign tick_count    = tick_count_q;
    assign cfg_err       = cfg_err_q;
    assign av_address    = addr_q;
    assign av_chipselect = cs_q;
    assign av_write_n    = wn_q;
    assign av_writedata  = wd_q;

`ifdef TIMER_HOST_SNAP_EN
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^av_readdata;
`endif

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Bench for timer_host_ctrl: two instances (continuous and one-shot) share
// one behavioural interval-timer model selected by 'sel'. Expected bus
// accesses are queued by each test and popped by a bus monitor.

module tb_timer_host_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_r = 1'b0;
    logic        stop_r = 1'b0;
    logic [31:0] period_r = '0;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // DUT 0: continuous
    logic        busy0, running0, tick0, cfg0, cs0, wn0, irq0;
    logic [15:0] tc0, wd0, rd0;
    logic [2:0]  addr0;
    // DUT 1: one-shot
    logic        busy1, running1, tick1, cfg1, cs1, wn1, irq1;
    logic [15:0] tc1, wd1, rd1;
    logic [2:0]  addr1;
`ifdef TIMER_HOST_SNAP_EN
    logic        snap_req_r = 1'b0;
    logic [31:0] snap_value0, unused_snap_value1;
    logic        snap_valid0, unused_snap_valid1;
`endif

    timer_host_ctrl #(.CONTINUOUS(1), .TICK_W(16), .MIN_PERIOD(3)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .start(start_r && sel == 0), .stop(stop_r && sel == 0), .period(period_r),
        .busy(busy0), .running(running0), .tick(tick0), .tick_count(tc0),
        .cfg_err(cfg0), .av_address(addr0), .av_chipselect(cs0),
        .av_write_n(wn0), .av_writedata(wd0), .av_readdata(rd0), .av_irq(irq0)
`ifdef TIMER_HOST_SNAP_EN
        , .snap_req(snap_req_r && sel == 0), .snap_value(snap_value0), .snap_valid(snap_valid0)
`endif
    );

    timer_host_ctrl #(.CONTINUOUS(0), .TICK_W(16), .MIN_PERIOD(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .start(start_r && sel == 1), .stop(stop_r && sel == 1), .period(period_r),
        .busy(busy1), .running(running1), .tick(tick1), .tick_count(tc1),
        .cfg_err(cfg1), .av_address(addr1), .av_chipselect(cs1),
        .av_write_n(wn1), .av_writedata(wd1), .av_readdata(rd1), .av_irq(irq1)
`ifdef TIMER_HOST_SNAP_EN
        , .snap_req(1'b0), .snap_value(unused_snap_value1), .snap_valid(unused_snap_valid1)
`endif
    );

    // Selected DUT view
    logic        b_cs, b_wn, b_tick, b_busy, b_running, b_cfg;
    logic [2:0]  b_addr;
    logic [15:0] b_wd, b_tc;
    assign b_cs      = (sel == 1) ? cs1 : cs0;
    assign b_wn      = (sel == 1) ? wn1 : wn0;
    assign b_addr    = (sel == 1) ? addr1 : addr0;
    assign b_wd      = (sel == 1) ? wd1 : wd0;
    assign b_tick    = (sel == 1) ? tick1 : tick0;
    assign b_tc      = (sel == 1) ? tc1 : tc0;
    assign b_busy    = (sel == 1) ? busy1 : busy0;
    assign b_running = (sel == 1) ? running1 : running0;
    assign b_cfg     = (sel == 1) ? cfg1 : cfg0;

    // Interval timer model
    logic [15:0] m_pl, m_ph, m_rd;
    logic        m_cont, m_ito, m_run, m_to;
    logic [31:0] m_cnt, m_snap;
    logic        m_irq;
    assign m_irq = m_to & m_ito;
    assign irq0  = m_irq && sel == 0;
    assign irq1  = m_irq && sel == 1;
    assign rd0   = (sel == 0) ? m_rd : 16'h0;
    assign rd1   = (sel == 1) ? m_rd : 16'h0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pl <= '0; m_ph <= '0; m_rd <= '0; m_cont <= 1'b0; m_ito <= 1'b0;
            m_run <= 1'b0; m_to <= 1'b0; m_cnt <= '0; m_snap <= '0;
        end else begin
            m_rd <= '0;
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_to  <= 1'b1;
                    m_cnt <= {m_ph, m_pl};
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (b_cs && !b_wn) begin
                case (b_addr)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_cont <= b_wd[1];
                        m_ito  <= b_wd[0];
                        if (b_wd[3]) m_run <= 1'b0;
                        else if (b_wd[2]) begin
                            m_run <= 1'b1;
                            m_cnt <= {m_ph, m_pl};
                        end
                    end
                    3'd2: m_pl <= b_wd;
                    3'd3: m_ph <= b_wd;
                    3'd4: m_snap <= m_cnt;
                    default: ;
                endcase
            end
            if (b_cs && b_wn) begin
                if (b_addr == 3'd4) m_rd <= m_snap[15:0];
                if (b_addr == 3'd5) m_rd <= m_snap[31:16];
            end
        end
    end

    // Bus scoreboard: {write_n, address, writedata}
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    function automatic logic [19:0] bw(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction
    function automatic logic [19:0] br(input logic [2:0] a);
        return {1'b1, a, 16'h0000};
    endfunction

    always @(negedge clk) begin
        if (reset_n && b_cs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: got wn=%0d addr=%0d data=%h, required no access",
                         b_wn, b_addr, b_wd);
            end else begin
                mon_e = exp_q.pop_front();
                if ({b_wn, b_addr, b_wd} !== mon_e) begin
                    errors++;
                    $display("FAIL bus_access: got wn=%0d addr=%0d data=%h, required wn=%0d addr=%0d data=%h",
                             b_wn, b_addr, b_wd, mon_e[19], mon_e[18:16], mon_e[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (b_busy && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (b_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: got busy=%0d, required 0", nm, b_busy);
        end
    endtask

    task automatic check_queue_empty(input string nm);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_access: got %0d pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        checks++;
        if ({busy0, running0, tick0, cfg0, cs0, wn0, addr0, wd0, tc0} !== {6'b000001, 3'd0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_dut0: got %h, required %h",
                     {busy0, running0, tick0, cfg0, cs0, wn0, addr0, wd0, tc0}, {6'b000001, 3'd0, 16'h0, 16'h0});
        end
        checks++;
        if ({busy1, running1, tick1, cfg1, cs1, wn1, addr1, wd1, tc1} !== {6'b000001, 3'd0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_dut1: got %h, required %h",
                     {busy1, running1, tick1, cfg1, cs1, wn1, addr1, wd1, tc1}, {6'b000001, 3'd0, 16'h0, 16'h0});
        end
        reset_n = 1'b1;
        step();
    endtask

    // Start latency plus a stop raised during configuration.
    task automatic test_start_latency();
        sel = 0;
        exp_q.push_back(bw(3'd2, 16'h86A0));
        exp_q.push_back(bw(3'd3, 16'h0001));
        exp_q.push_back(bw(3'd1, 16'h0007));
        exp_q.push_back(bw(3'd1, 16'h0008));
        exp_q.push_back(bw(3'd0, 16'h0000));
        start_r = 1'b1; period_r = 32'h0001_86A0;
        step();                                  // cycle 1
        start_r = 1'b0;
        checks++;
        if ({b_busy, b_cs, b_addr} !== {2'b11, 3'd2}) begin
            errors++;
            $display("FAIL lat_cycle1: got busy=%0d cs=%0d addr=%0d, required 1 1 2", b_busy, b_cs, b_addr);
        end
        step();                                  // cycle 2
        stop_r = 1'b1;
        checks++;
        if ({b_cs, b_addr} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL lat_cycle2: got cs=%0d addr=%0d, required 1 3", b_cs, b_addr);
        end
        step();                                  // cycle 3
        stop_r = 1'b0;
        checks++;
        if ({b_cs, b_addr, b_running} !== {1'b1, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL lat_cycle3: got cs=%0d addr=%0d running=%0d, required 1 1 0", b_cs, b_addr, b_running);
        end
        step();                                  // cycle 4
        checks++;
        if ({b_running, b_cs} !== 2'b10) begin
            errors++;
            $display("FAIL lat_cycle4_run: got running=%0d cs=%0d, required 1 0", b_running, b_cs);
        end
        step();                                  // cycle 5: pending stop honoured
        checks++;
        if ({b_cs, b_addr} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL pend_stop_cycle5: got cs=%0d addr=%0d, required 1 1", b_cs, b_addr);
        end
        step(); step();                          // cycle 7
        checks++;
        if ({b_busy, b_running} !== 2'b00) begin
            errors++;
            $display("FAIL pend_stop_idle: got busy=%0d running=%0d, required 0 0", b_busy, b_running);
        end
        check_queue_empty("latency");
    endtask

    task automatic test_cfg_err();
        sel = 0;
        start_r = 1'b1; period_r = 32'd2;
        step();
        start_r = 1'b0;
        checks++;
        if ({b_cfg, b_busy, b_cs} !== 3'b100) begin
            errors++;
            $display("FAIL cfg_err_pulse: got cfg=%0d busy=%0d cs=%0d, required 1 0 0", b_cfg, b_busy, b_cs);
        end
        step();
        checks++;
        if ({b_cfg, b_busy} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_err_oneshot: got cfg=%0d busy=%0d, required 0 0", b_cfg, b_busy);
        end
        // period == MIN_PERIOD is accepted; stop in the start cycle is pended.
        exp_q.push_back(bw(3'd2, 16'h0003));
        exp_q.push_back(bw(3'd3, 16'h0000));
        exp_q.push_back(bw(3'd1, 16'h0007));
        exp_q.push_back(bw(3'd1, 16'h0008));
        exp_q.push_back(bw(3'd0, 16'h0000));
        start_r = 1'b1; stop_r = 1'b1; period_r = 32'd3;
        step();
        start_r = 1'b0; stop_r = 1'b0;
        checks++;
        if ({b_busy, b_cfg} !== 2'b10) begin
            errors++;
            $display("FAIL min_period_accept: got busy=%0d cfg=%0d, required 1 0", b_busy, b_cfg);
        end
        wait_idle("min_period");
        check_queue_empty("min_period");
    endtask

    task automatic test_continuous();
        logic irq_prev;
        int   last_tick;
        int   got;
        sel = 0;
        exp_q.push_back(bw(3'd2, 16'h0009));
        exp_q.push_back(bw(3'd3, 16'h0000));
        exp_q.push_back(bw(3'd1, 16'h0007));
        for (int k = 0; k < 5; k++) exp_q.push_back(bw(3'd0, 16'h0000));
        start_r = 1'b1; period_r = 32'd9;
        step();
        start_r = 1'b0;
        last_tick = 0;
        for (int k = 1; k <= 5; k++) begin
            got = 0;
            irq_prev = 1'b0;
            for (int i = 0; i < 30 && got == 0; i++) begin
                irq_prev = irq0;
                step();
                if (b_tick) got = 1;
            end
            checks++;
            if (got == 0) begin
                errors++;
                $display("FAIL cont_tick_timeout: got no tick %0d, required tick", k);
            end else begin
                checks++;
                if ({irq_prev, b_cs, b_wn, b_addr} !== {3'b110, 3'd0}) begin
                    errors++;
                    $display("FAIL cont_status_after_irq: got irq_prev=%0d cs=%0d wn=%0d addr=%0d, required 1 1 0 0",
                             irq_prev, b_cs, b_wn, b_addr);
                end
                checks++;
                if (b_tc !== 16'(k)) begin
                    errors++;
                    $display("FAIL cont_tick_count: got %0d, required %0d", b_tc, k);
                end
                if (k > 1) begin
                    checks++;
                    if (cyc_n - last_tick != 10) begin
                        errors++;
                        $display("FAIL cont_tick_interval: got %0d, required 10", cyc_n - last_tick);
                    end
                end
                last_tick = cyc_n;
            end
        end
        step();
        exp_q.push_back(bw(3'd1, 16'h0008));
        exp_q.push_back(bw(3'd0, 16'h0000));
        stop_r = 1'b1;
        step();
        stop_r = 1'b0;
        wait_idle("cont");
        checks++;
        if (b_tc !== 16'd5) begin
            errors++;
            $display("FAIL cont_final_count: got %0d, required 5", b_tc);
        end
        check_queue_empty("cont");
    endtask

    task automatic test_stop_irq();
        int got;
        int ticks;
        sel = 0;
        exp_q.push_back(bw(3'd2, 16'h0009));
        exp_q.push_back(bw(3'd3, 16'h0000));
        exp_q.push_back(bw(3'd1, 16'h0007));
        start_r = 1'b1; period_r = 32'd9;
        step();
        start_r = 1'b0;
        step();
        start_r = 1'b1; period_r = 32'd2;        // start while busy: ignored
        step();
        start_r = 1'b0;
        checks++;
        if (b_cfg !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_cfg_err: got %0d, required 0", b_cfg);
        end
        checks++;
        if (b_tc !== 16'd0) begin
            errors++;
            $display("FAIL start_clears_count: got %0d, required 0", b_tc);
        end
        got = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            if (irq0) got = 1;
            else step();
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL stop_irq_timeout: got no irq, required irq");
        end
        exp_q.push_back(bw(3'd1, 16'h0008));
        exp_q.push_back(bw(3'd0, 16'h0000));
        stop_r = 1'b1;
        step();
        stop_r = 1'b0;
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            if (b_tick) ticks++;
            step();
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL stop_irq_no_tick: got %0d ticks, required 0", ticks);
        end
        wait_idle("stop_irq");
        checks++;
        if ({b_tc, m_run, m_to} !== {16'd0, 2'b00}) begin
            errors++;
            $display("FAIL stop_irq_final: got count=%0d run=%0d to=%0d, required 0 0 0", b_tc, m_run, m_to);
        end
        check_queue_empty("stop_irq");
    endtask

    task automatic test_oneshot();
        int ticks;
        sel = 1;
        exp_q.push_back(bw(3'd2, 16'h0014));
        exp_q.push_back(bw(3'd3, 16'h0000));
        exp_q.push_back(bw(3'd1, 16'h0005));
        exp_q.push_back(bw(3'd0, 16'h0000));
        start_r = 1'b1; period_r = 32'd20;
        step();
        start_r = 1'b0;
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            if (b_tick) ticks++;
            step();
        end
        checks++;
        if (ticks != 1) begin
            errors++;
            $display("FAIL oneshot_ticks: got %0d, required 1", ticks);
        end
        checks++;
        if ({b_busy, b_running, m_run, b_tc} !== {3'b000, 16'd1}) begin
            errors++;
            $display("FAIL oneshot_final: got busy=%0d running=%0d timer_run=%0d count=%0d, required 0 0 0 1",
                     b_busy, b_running, m_run, b_tc);
        end
        check_queue_empty("oneshot");
        sel = 0;
    endtask

`ifdef TIMER_HOST_SNAP_EN
    task automatic test_snap();
        int got;
        sel = 0;
        exp_q.push_back(bw(3'd2, 16'h0200));
        exp_q.push_back(bw(3'd3, 16'h0000));
        exp_q.push_back(bw(3'd1, 16'h0007));
        start_r = 1'b1; period_r = 32'h200;
        step();
        start_r = 1'b0;
        got = 0;
        for (int i = 0; i < 700 && got == 0; i++) begin
            if (m_cnt == 32'h124) got = 1;
            else step();
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL snap_counter_timeout: got counter=%h, required 124", m_cnt);
        end
        exp_q.push_back(bw(3'd4, 16'h0000));
        exp_q.push_back(br(3'd4));
        exp_q.push_back(br(3'd5));
        snap_req_r = 1'b1;
        step();
        snap_req_r = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step();
            if (snap_valid0) got = 1;
        end
        checks++;
        if (got == 0 || snap_value0 !== 32'h0000_0123) begin
            errors++;
            $display("FAIL snap_value: got valid=%0d value=%h, required 1 00000123", got, snap_value0);
        end
        exp_q.push_back(bw(3'd1, 16'h0008));
        exp_q.push_back(bw(3'd0, 16'h0000));
        stop_r = 1'b1;
        step();
        stop_r = 1'b0;
        wait_idle("snap");
        check_queue_empty("snap");
    endtask
`endif

    initial begin
        test_reset();
        test_start_latency();
        test_cfg_err();
        test_continuous();
        test_stop_irq();
        test_oneshot();
`ifdef TIMER_HOST_SNAP_EN
        test_snap();
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
